// File: rtl/storage_exerciser_pkg.sv
// storage_exerciser_pkg
//   Shared types and constants for the storage exerciser and its LFSR.
//   Contents: FSM state enum, LFSR feedback tap mask, drain length,
//   error counter ceiling, and the helper functions used by the datapath.
package storage_exerciser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Right-shifting Fibonacci form of x^8+x^6+x^5+x^4+1: the polynomial term
  // x^k feeds back from state bit (8-k), i.e. bits 0, 2, 3 and 4.
  localparam logic [7:0] LFSR_TAP_MASK = 8'h1D;

  // Two extra edges after the last drive let the q_b (two-edge) check land.
  localparam int unsigned DRAIN_CYCLES = 2;

  localparam logic [7:0] ERR_MAX = 8'd255;

  // Next LFSR state: XOR of tapped bits enters at the MSB, bit 0 leaves.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    logic fb;
    fb = ^(cur & LFSR_TAP_MASK);
    return {fb, cur[7:1]};
  endfunction

  // Saturating accumulate of up to three mismatches per edge.
  function automatic logic [7:0] err_sat_add(input logic [7:0] acc,
                                             input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, acc} + {7'd0, inc};
    return sum[8] ? ERR_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/storage_exerciser_lfsr8.sv
// lfsr8
//   8-bit Fibonacci LFSR with synchronous load and shift enables.
//   Ports:
//     clk   - clock, rising edge
//     rst   - synchronous active-high reset, loads seed
//     load  - load seed (has priority over shift)
//     shift - advance one step
//     seed  - value loaded on rst or load
//     state - current register contents
module lfsr8
  import storage_exerciser_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] seed,
  output logic [7:0] state
);

  logic [7:0] state_r;

  // LFSR state register: reset/load seed, otherwise shift or hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= seed;
    end else if (load) begin
      state_r <= seed;
    end else if (shift) begin
      state_r <= lfsr_next(state_r);
    end else begin
      state_r <= state_r;
    end
  end

  assign state = state_r;

endmodule

// File: rtl/storage_exerciser.sv
// storage_exerciser
//   Stimulus driver and readback checker for a latch / posedge FF /
//   negedge FF trio that shares clk with this block. d is driven from an
//   LFSR, one bit per DRIVE cycle; q_a/q_c are checked against the bit
//   driven one edge earlier and q_b against the bit driven two edges earlier.
//   Ports:
//     clk, rst         - clock; synchronous active-high reset
//     start            - starts a run, honoured only in IDLE and DONE
//     d                - registered stimulus bit to the trio
//     q_a, q_b, q_c    - trio readbacks (latch, posedge FF, negedge FF)
//     busy             - run in progress (DRIVE or DRAIN)
//     done             - run finished, results held
//     pass             - valid with done; 1 when no mismatch was seen
//     err_count        - saturating mismatch count for this run
//     first_fail       - {vec_index, fail_mask} of the first mismatch, only
//                        when STORAGE_EXERCISER_FIRST_FAIL_EN is defined
//   Parameters: NUM_VECTORS (1..255), LFSR_SEED (nonzero).
module storage_exerciser
  import storage_exerciser_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 64,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       d,
  input  logic       q_a,
  input  logic       q_b,
  input  logic       q_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count
`ifdef STORAGE_EXERCISER_FIRST_FAIL_EN
  ,
  output logic [9:0] first_fail
`endif
);

  localparam logic [7:0] LAST_VEC   = 8'(NUM_VECTORS - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_e     state_r, state_nxt_s;
  logic       d_r, d_nxt_s;
  logic       busy_r, done_r, pass_r;
  logic [7:0] err_r, err_nxt_s;
  logic [7:0] vec_cnt_r, vec_cnt_nxt_s;
  logic [1:0] drain_cnt_r, drain_cnt_nxt_s;
  // hist[1] = bit driven one edge ago, hist[0] = two edges ago.
  logic [1:0] hist_r, hist_nxt_s;
  logic [1:0] vld_r, vld_nxt_s;

  logic       lfsr_load_s, lfsr_shift_s, lfsr_lock_s;
  logic [7:0] lfsr_state_s;

  logic       chk_en_s, run_start_s;
  logic       mis_a_s, mis_b_s, mis_c_s;
  logic [1:0] mis_cnt_s;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load_s),
    .shift (lfsr_shift_s),
    .seed  (LFSR_SEED),
    .state (lfsr_state_s)
  );

  // An all-zero LFSR can never leave that state; reload the seed instead.
  assign lfsr_lock_s = (lfsr_state_s == 8'h00);

  assign chk_en_s    = (state_r == DRIVE) || (state_r == DRAIN);
  assign run_start_s = start && ((state_r == IDLE) || (state_r == DONE));

  // Only valid history bits are ever compared.
  assign mis_a_s   = chk_en_s & vld_r[1] & (q_a ^ hist_r[1]);
  assign mis_c_s   = chk_en_s & vld_r[1] & (q_c ^ hist_r[1]);
  assign mis_b_s   = chk_en_s & vld_r[0] & (q_b ^ hist_r[0]);
  assign mis_cnt_s = {1'b0, mis_a_s} + {1'b0, mis_b_s} + {1'b0, mis_c_s};

  // Next-state and datapath next values for the run FSM.
  always_comb begin
    state_nxt_s     = state_r;
    d_nxt_s         = d_r;
    err_nxt_s       = err_r;
    vec_cnt_nxt_s   = vec_cnt_r;
    drain_cnt_nxt_s = drain_cnt_r;
    hist_nxt_s      = hist_r;
    vld_nxt_s       = vld_r;
    lfsr_load_s     = 1'b0;
    lfsr_shift_s    = 1'b0;
    case (state_r)
      IDLE: begin
        d_nxt_s = 1'b0;
        if (start) begin
          state_nxt_s     = DRIVE;
          lfsr_load_s     = 1'b1;
          err_nxt_s       = 8'd0;
          vec_cnt_nxt_s   = 8'd0;
          drain_cnt_nxt_s = 2'd0;
          hist_nxt_s      = 2'b00;
          vld_nxt_s       = 2'b00;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DRIVE: begin
        err_nxt_s     = err_sat_add(err_r, mis_cnt_s);
        d_nxt_s       = lfsr_state_s[0];
        lfsr_load_s   = lfsr_lock_s;
        lfsr_shift_s  = ~lfsr_lock_s;
        hist_nxt_s    = {lfsr_state_s[0], hist_r[1]};
        vld_nxt_s     = {1'b1, vld_r[1]};
        vec_cnt_nxt_s = vec_cnt_r + 8'd1;
        if (vec_cnt_r == LAST_VEC) begin
          state_nxt_s     = DRAIN;
          drain_cnt_nxt_s = 2'd0;
        end else begin
          state_nxt_s = DRIVE;
        end
      end
      DRAIN: begin
        // No new bits: shift an invalid slot in behind the last driven bit.
        err_nxt_s  = err_sat_add(err_r, mis_cnt_s);
        hist_nxt_s = {hist_r[1], hist_r[1]};
        vld_nxt_s  = {1'b0, vld_r[1]};
        if (drain_cnt_r == DRAIN_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s     = DRAIN;
          drain_cnt_nxt_s = drain_cnt_r + 2'd1;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt_s     = DRIVE;
          lfsr_load_s     = 1'b1;
          err_nxt_s       = 8'd0;
          vec_cnt_nxt_s   = 8'd0;
          drain_cnt_nxt_s = 2'd0;
          hist_nxt_s      = 2'b00;
          vld_nxt_s       = 2'b00;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        d_nxt_s     = 1'b0;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      d_r         <= 1'b0;
      err_r       <= 8'd0;
      vec_cnt_r   <= 8'd0;
      drain_cnt_r <= 2'd0;
      hist_r      <= 2'b00;
      vld_r       <= 2'b00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      d_r         <= d_nxt_s;
      err_r       <= err_nxt_s;
      vec_cnt_r   <= vec_cnt_nxt_s;
      drain_cnt_r <= drain_cnt_nxt_s;
      hist_r      <= hist_nxt_s;
      vld_r       <= vld_nxt_s;
      busy_r      <= (state_nxt_s == DRIVE) || (state_nxt_s == DRAIN);
      done_r      <= (state_nxt_s == DONE);
      pass_r      <= (state_nxt_s == DONE) && (err_nxt_s == 8'd0);
    end
  end

  assign d         = d_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;

`ifdef STORAGE_EXERCISER_FIRST_FAIL_EN
  // Vector indices travelling alongside hist[1] and hist[0].
  logic [7:0] idx1_r, idx1_nxt_s, idx0_r, idx0_nxt_s;
  logic [9:0] ff_r, ff_nxt_s;
  logic       ff_got_r, ff_got_nxt_s;

  // Index tracking and one-shot capture of the first failing check.
  always_comb begin
    idx1_nxt_s   = idx1_r;
    idx0_nxt_s   = idx0_r;
    ff_nxt_s     = ff_r;
    ff_got_nxt_s = ff_got_r;
    if (state_r == DRIVE) begin
      idx1_nxt_s = vec_cnt_r;
      idx0_nxt_s = idx1_r;
    end else if (state_r == DRAIN) begin
      idx0_nxt_s = idx1_r;
    end else begin
      idx1_nxt_s = idx1_r;
    end
    if (run_start_s) begin
      ff_nxt_s     = 10'h3FF;
      ff_got_nxt_s = 1'b0;
    end else if (!ff_got_r && (mis_a_s || mis_b_s || mis_c_s)) begin
      // Lowest mask code wins when several outputs fail on the same edge.
      ff_got_nxt_s = 1'b1;
      if (mis_a_s) begin
        ff_nxt_s = {idx1_r, 2'b00};
      end else if (mis_b_s) begin
        ff_nxt_s = {idx0_r, 2'b01};
      end else begin
        ff_nxt_s = {idx1_r, 2'b10};
      end
    end else begin
      ff_nxt_s = ff_r;
    end
  end

  // First-fail registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx1_r   <= 8'd0;
      idx0_r   <= 8'd0;
      ff_r     <= 10'h3FF;
      ff_got_r <= 1'b0;
    end else begin
      idx1_r   <= idx1_nxt_s;
      idx0_r   <= idx0_nxt_s;
      ff_r     <= ff_nxt_s;
      ff_got_r <= ff_got_nxt_s;
    end
  end

  assign first_fail = ff_r;
`endif

endmodule

// File: tb/tb_storage_exerciser.sv
// tb_storage_exerciser
//   Two exercisers (64 and 255 vectors) each wired to a behavioural trio
//   model with selectable faults. The stimulus pushes the expected run result
//   into a queue; monitors pop and compare when done rises, and compare the
//   d stream against a golden LFSR sequence.
module tb_storage_exerciser;

  typedef struct {
    int err;
    int pass;
    int ff;
  } want_t;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic       d_a, busy_a, done_a, pass_a;
  logic       d_b, busy_b, done_b, pass_b;
  logic [7:0] err_a, err_b;
  logic       qa_a, qb_a, qc_a, qa_b, qb_b, qc_b;
  logic       qa_a_m, qb_a_m, qc_a_m, qa_b_m, qb_b_m, qc_b_m;
`ifdef STORAGE_EXERCISER_FIRST_FAIL_EN
  logic [9:0] ff_a, ff_b;
`endif

  int    fault_a;    // 0 good, 1 q_b stuck 0, 2 all inverted, 3 q_c bad at vec 17
  int    cur_vec_a;
  bit    dchk_en;
  int    n_run, n_fail;
  want_t want_a[$];
  want_t want_b[$];
  logic  dq[$];
  logic  gold[0:63];
  int    ones;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  storage_exerciser #(.NUM_VECTORS(64), .LFSR_SEED(8'hA5)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .d(d_a),
    .q_a(qa_a), .q_b(qb_a), .q_c(qc_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a)
`ifdef STORAGE_EXERCISER_FIRST_FAIL_EN
    , .first_fail(ff_a)
`endif
  );

  storage_exerciser #(.NUM_VECTORS(255), .LFSR_SEED(8'hA5)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .d(d_b),
    .q_a(qa_b), .q_b(qb_b), .q_c(qc_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b)
`ifdef STORAGE_EXERCISER_FIRST_FAIL_EN
    , .first_fail(ff_b)
`endif
  );

  // Trio model for DUT A: latch transparent while clk high, two flops.
  always_latch begin
    if (clk) qa_a_m = d_a;
  end
  always @(posedge clk) qb_a_m <= d_a;
  always @(negedge clk) qc_a_m <= (fault_a == 3 && cur_vec_a == 17) ? ~d_a : d_a;
  assign qa_a = (fault_a == 2) ? ~qa_a_m : qa_a_m;
  assign qb_a = (fault_a == 1) ? 1'b0 : ((fault_a == 2) ? ~qb_a_m : qb_a_m);
  assign qc_a = (fault_a == 2) ? ~qc_a_m : qc_a_m;

  // Trio model for DUT B, every output inverted.
  always_latch begin
    if (clk) qa_b_m = d_b;
  end
  always @(posedge clk) qb_b_m <= d_b;
  always @(negedge clk) qc_b_m <= d_b;
  assign qa_b = ~qa_b_m;
  assign qb_b = ~qb_b_m;
  assign qc_b = ~qc_b_m;

  task automatic chk(input string name, input int act, input int want);
    n_run++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // Result monitor for DUT A: compare at done rise, recheck hold later.
  initial begin
    logic  prev;
    int    hold;
    want_t cur;
    prev = 1'b0;
    hold = 0;
    forever begin
      @(posedge clk); #1;
      if (done_a && !prev) begin
        if (want_a.size() == 0) begin
          chk("a_unexpected_done", want_a.size(), 1);
        end else begin
          cur = want_a.pop_front();
          chk("a_err_count", err_a, cur.err);
          chk("a_pass", pass_a, cur.pass);
`ifdef STORAGE_EXERCISER_FIRST_FAIL_EN
          chk("a_first_fail", ff_a, cur.ff);
`endif
          hold = 4;
        end
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) begin
          chk("a_err_hold", err_a, cur.err);
          chk("a_done_hold", done_a, 1);
        end
      end
      prev = done_a;
    end
  end

  // Result monitor for DUT B (saturation run).
  initial begin
    logic  prev;
    int    hold;
    want_t cur;
    prev = 1'b0;
    hold = 0;
    forever begin
      @(posedge clk); #1;
      if (done_b && !prev) begin
        if (want_b.size() == 0) begin
          chk("b_unexpected_done", want_b.size(), 1);
        end else begin
          cur = want_b.pop_front();
          chk("b_err_count", err_b, cur.err);
          chk("b_pass", pass_b, cur.pass);
`ifdef STORAGE_EXERCISER_FIRST_FAIL_EN
          chk("b_first_fail", ff_b, cur.ff);
`endif
          hold = 4;
        end
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) chk("b_err_hold_no_wrap", err_b, cur.err);
      end
      prev = done_b;
    end
  end

  // d stream monitor: skips the start cycle, then one sample per busy cycle.
  initial begin
    logic bprev;
    bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (dchk_en && busy_a && bprev) begin
        if (dq.size() == 0) chk("d_extra_sample", dq.size(), 1);
        else chk("d_stream", d_a, dq.pop_front());
      end
      bprev = busy_a;
    end
  end

  task automatic check_reset_a(input string tag);
    chk({tag, "_d"}, d_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_pass"}, pass_a, 0);
    chk({tag, "_err"}, err_a, 0);
`ifdef STORAGE_EXERCISER_FIRST_FAIL_EN
    chk({tag, "_ff"}, ff_a, 10'h3FF);
`endif
  endtask

  // One run on DUT A; result expectation goes to the scoreboard.
  task automatic run_a(input int mode, input want_t w);
    int c;
    bit got;
    fault_a   = mode;
    cur_vec_a = -1;
    want_a.push_back(w);
    start_a = 1'b1;
    c = 0;
    got = 1'b0;
    while (!got && c < 400) begin
      @(posedge clk); #1;
      c++;
      if (c == 1) start_a = 1'b0;
      cur_vec_a = c - 2;
      if (done_a) got = 1'b1;
    end
    chk("a_done_latency", c, 1 + 64 + 2);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    want_t w;
    logic [7:0] s;
    logic fb;
    n_run = 0; n_fail = 0;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    fault_a = 0; cur_vec_a = -1; dchk_en = 1'b0;

    // Golden sequence, seed A5, taps x^8,x^6,x^5,x^4 -> bits 0,2,3,4.
    s = 8'hA5;
    ones = 0;
    for (int i = 0; i < 64; i++) begin
      gold[i] = s[0];
      if (s[0]) ones++;
      fb = s[0] ^ s[2] ^ s[3] ^ s[4];
      s = {fb, s[7:1]};
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_a("rst_a");
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_err", err_b, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Good trio: pass, golden d stream (last bit held through drain).
    for (int i = 0; i < 64; i++) dq.push_back(gold[i]);
    dq.push_back(gold[63]);
    dchk_en = 1'b1;
    w.err = 0; w.pass = 1; w.ff = 10'h3FF;
    run_a(0, w);
    dchk_en = 1'b0;
    chk("d_stream_all_seen", dq.size(), 0);

    // q_b stuck at 0: one error per driven 1; first q_b check hits bit 0 = 1.
    w.err = ones; w.pass = 0; w.ff = {8'd0, 2'b01};
    run_a(1, w);

    // All outputs inverted: 3 x 64 with no saturation.
    w.err = 192; w.pass = 0; w.ff = {8'd0, 2'b00};
    run_a(2, w);

    // 255 vectors, all inverted: 765 mismatches saturate at 255.
    begin
      int c;
      bit got;
      w.err = 255; w.pass = 0; w.ff = {8'd0, 2'b00};
      want_b.push_back(w);
      start_b = 1'b1;
      c = 0;
      got = 1'b0;
      while (!got && c < 600) begin
        @(posedge clk); #1;
        c++;
        if (c == 1) start_b = 1'b0;
        if (done_b) got = 1'b1;
      end
      chk("b_done_latency", c, 1 + 255 + 2);
      repeat (6) @(posedge clk);
      #1;
    end

    // Abort at vector 10 (with errors accumulating), then a clean run.
    begin
      bit saw;
      fault_a = 2;
      start_a = 1'b1;
      for (int c = 1; c <= 12; c++) begin
        @(posedge clk); #1;
        if (c == 1) start_a = 1'b0;
      end
      chk("abort_busy_before", busy_a, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_a("abort");
      rst = 1'b0;
      saw = 1'b0;
      for (int c = 0; c < 80; c++) begin
        @(posedge clk); #1;
        if (done_a) saw = 1'b1;
      end
      chk("abort_no_done", saw, 0);
    end
    w.err = 0; w.pass = 1; w.ff = 10'h3FF;
    run_a(0, w);

    // q_c wrong only for vector 17.
    w.err = 1; w.pass = 0; w.ff = {8'd17, 2'b10};
    run_a(3, w);

    repeat (2) @(posedge clk);
    #1;
    chk("a_results_consumed", want_a.size(), 0);
    chk("b_results_consumed", want_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_run, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
